// File: rtl/memory_port_arbiter.sv
// Three-way round-robin arbiter for the single-port cell memory: one requester at a time
// owns the memory port for OP_CYCLES cycles, then gets a one-cycle completion pulse.
module memory_port_arbiter #(
  parameter int OP_CYCLES = 4,
  parameter int ADDR_W    = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        i_req,
  input  logic [1:0]        i_op0,
  input  logic [1:0]        i_op1,
  input  logic [1:0]        i_op2,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [ADDR_W-1:0] i_addr2,
  input  logic [2:0]        i_wdata,
  output logic [2:0]        o_grant,
  output logic [2:0]        o_done,
  output logic              o_rdata,
  output logic [1:0]        o_mem_operation,
  output logic [ADDR_W-1:0] o_mem_address,
  output logic              o_mem_wdata,
  input  logic              i_mem_rdata,
  output logic              o_busy
);

  localparam int                 CNT_W    = $clog2(OP_CYCLES) + 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(OP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
  localparam logic [1:0]         OP_IDLE  = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACTIVE = 2'b01,
    S_DONE   = 2'b10
  } state_t;

  state_t              state_q;
  logic [2:0]          grant_q;
  logic [2:0]          done_q;
  logic                rdata_q;
  logic                busy_q;
  logic [1:0]          mem_op_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_wdata_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [1:0]          owner_q;
  logic [1:0]          last_q;

  logic [1:0]          pri0_d;
  logic [1:0]          pri1_d;
  logic [1:0]          pri2_d;
  logic [1:0]          sel_idx_d;
  logic [2:0]          sel_grant_d;
  logic [1:0]          sel_op_d;
  logic [ADDR_W-1:0]   sel_addr_d;
  logic                sel_wdata_d;

  function automatic logic [1:0] rr_next(input logic [1:0] idx);
    logic [1:0] nxt;
    case (idx)
      2'd0:    nxt = 2'd1;
      2'd1:    nxt = 2'd2;
      default: nxt = 2'd0;
    endcase
    return nxt;
  endfunction

  // Round-robin pick, searching from one past the last requester served
  always_comb begin
    pri0_d = rr_next(last_q);
    pri1_d = rr_next(pri0_d);
    pri2_d = rr_next(pri1_d);
    if (i_req[pri0_d]) begin
      sel_idx_d = pri0_d;
    end else if (i_req[pri1_d]) begin
      sel_idx_d = pri1_d;
    end else if (i_req[pri2_d]) begin
      sel_idx_d = pri2_d;
    end else begin
      sel_idx_d = pri0_d;
    end
  end

  // Operand mux for the selected requester
  always_comb begin
    sel_grant_d = 3'b000;
    sel_op_d    = OP_IDLE;
    sel_addr_d  = {ADDR_W{1'b0}};
    sel_wdata_d = 1'b0;
    case (sel_idx_d)
      2'd0: begin
        sel_grant_d = 3'b001;
        sel_op_d    = i_op0;
        sel_addr_d  = i_addr0;
        sel_wdata_d = i_wdata[0];
      end
      2'd1: begin
        sel_grant_d = 3'b010;
        sel_op_d    = i_op1;
        sel_addr_d  = i_addr1;
        sel_wdata_d = i_wdata[1];
      end
      2'd2: begin
        sel_grant_d = 3'b100;
        sel_op_d    = i_op2;
        sel_addr_d  = i_addr2;
        sel_wdata_d = i_wdata[2];
      end
      default: begin
        sel_grant_d = 3'b000;
        sel_op_d    = OP_IDLE;
        sel_addr_d  = {ADDR_W{1'b0}};
        sel_wdata_d = 1'b0;
      end
    endcase
  end

  // Grant FSM; the memory-port registers double as the latched request
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      grant_q     <= 3'b000;
      done_q      <= 3'b000;
      rdata_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_op_q    <= OP_IDLE;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      owner_q     <= 2'd0;
      last_q      <= 2'd2;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 3'b000;
          if (|i_req) begin
            state_q     <= S_ACTIVE;
            grant_q     <= sel_grant_d;
            owner_q     <= sel_idx_d;
            busy_q      <= 1'b1;
            mem_op_q    <= sel_op_d;
            mem_addr_q  <= sel_addr_d;
            mem_wdata_q <= sel_wdata_d;
            cnt_q       <= {CNT_W{1'b0}};
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_ACTIVE: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) begin
            state_q     <= S_DONE;
            rdata_q     <= i_mem_rdata;
            done_q      <= grant_q;
            grant_q     <= 3'b000;
            mem_op_q    <= OP_IDLE;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= 1'b0;
          end else begin
            state_q <= S_ACTIVE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 3'b000;
          busy_q  <= 1'b0;
          last_q  <= owner_q;
        end
        default: begin
          state_q     <= S_IDLE;
          grant_q     <= 3'b000;
          done_q      <= 3'b000;
          busy_q      <= 1'b0;
          mem_op_q    <= OP_IDLE;
          mem_addr_q  <= {ADDR_W{1'b0}};
          mem_wdata_q <= 1'b0;
          cnt_q       <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign o_grant         = grant_q;
  assign o_done          = done_q;
  assign o_rdata         = rdata_q;
  assign o_busy          = busy_q;
  assign o_mem_operation = mem_op_q;
  assign o_mem_address   = mem_addr_q;
  assign o_mem_wdata     = mem_wdata_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Bench for memory_port_arbiter: directed scenarios plus random traffic, every cycle
// compared against a timeline model of the grant/hold/done sequence.
module tb_memory_port_arbiter;
  localparam int OPC = 4;
  localparam int AW  = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    i_req;
  logic [1:0]    i_op0, i_op1, i_op2;
  logic [AW-1:0] i_addr0, i_addr1, i_addr2;
  logic [2:0]    i_wdata;
  logic          i_mem_rdata;

  logic [2:0]    o_grant, o_done;
  logic          o_rdata, o_mem_wdata, o_busy;
  logic [1:0]    o_mem_operation;
  logic [AW-1:0] o_mem_address;

  logic [2:0]    q_grant, q_done;
  logic          q_rdata, q_mem_wdata, q_busy;
  logic [1:0]    q_mem_operation;
  logic [AW-1:0] q_mem_address;

  always #5 clk = ~clk;

  memory_port_arbiter #(.OP_CYCLES(OPC), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .i_req(i_req),
    .i_op0(i_op0), .i_op1(i_op1), .i_op2(i_op2),
    .i_addr0(i_addr0), .i_addr1(i_addr1), .i_addr2(i_addr2),
    .i_wdata(i_wdata), .o_grant(o_grant), .o_done(o_done), .o_rdata(o_rdata),
    .o_mem_operation(o_mem_operation), .o_mem_address(o_mem_address),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .o_busy(o_busy)
  );

  memory_port_arbiter #(.OP_CYCLES(1), .ADDR_W(AW)) dut1 (
    .clk(clk), .rst(rst), .i_req(i_req),
    .i_op0(i_op0), .i_op1(i_op1), .i_op2(i_op2),
    .i_addr0(i_addr0), .i_addr1(i_addr1), .i_addr2(i_addr2),
    .i_wdata(i_wdata), .o_grant(q_grant), .o_done(q_done), .o_rdata(q_rdata),
    .o_mem_operation(q_mem_operation), .o_mem_address(q_mem_address),
    .o_mem_wdata(q_mem_wdata), .i_mem_rdata(i_mem_rdata), .o_busy(q_busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: m_age counts edges since the request was taken (0 = port free)
  int            m_age   = 0;
  int            m_owner = 0;
  int            m_last  = 2;
  logic [1:0]    m_op;
  logic [AW-1:0] m_addr;
  logic          m_wd;
  logic          m_rdata = 1'b0;

  logic          s_rst;
  logic [2:0]    s_req;
  logic [1:0]    s_op[3];
  logic [AW-1:0] s_addr[3];
  logic [2:0]    s_wd;
  logic          s_mrd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit found;
    if (s_rst) begin
      m_age   = 0;
      m_last  = 2;
      m_rdata = 1'b0;
    end else if (m_age == 0) begin
      found = 1'b0;
      for (int k = 1; k <= 3; k++) begin
        if (!found && s_req[(m_last + k) % 3]) begin
          m_owner = (m_last + k) % 3;
          found   = 1'b1;
        end
      end
      if (found) begin
        m_op   = s_op[m_owner];
        m_addr = s_addr[m_owner];
        m_wd   = s_wd[m_owner];
        m_age  = 1;
      end
    end else begin
      m_age++;
      if (m_age == OPC + 1) m_rdata = s_mrd;
      if (m_age == OPC + 2) begin
        m_age  = 0;
        m_last = m_owner;
      end
    end
  endtask

  task automatic compare();
    bit act, dn;
    act = (m_age >= 1) && (m_age <= OPC);
    dn  = (m_age == OPC + 1);
    chk("grant",  o_grant, act ? (3'b001 << m_owner) : 3'b000);
    chk("done",   o_done,  dn  ? (3'b001 << m_owner) : 3'b000);
    chk("busy",   o_busy,  m_age != 0);
    chk("mem_op", o_mem_operation, act ? m_op : 2'b10);
    chk("mem_addr", o_mem_address, act ? m_addr : 6'd0);
    chk("mem_wdata", o_mem_wdata, act ? m_wd : 1'b0);
    chk("rdata",  o_rdata, m_rdata);
  endtask

  task automatic step();
    s_rst = rst; s_req = i_req; s_wd = i_wdata; s_mrd = i_mem_rdata;
    s_op[0] = i_op0; s_op[1] = i_op1; s_op[2] = i_op2;
    s_addr[0] = i_addr0; s_addr[1] = i_addr1; s_addr[2] = i_addr2;
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    compare();
  endtask

  int         dn_cyc[$];
  logic [2:0] dn_val[$];

  initial begin
    rst = 1'b1; i_req = 3'b000; i_wdata = 3'b000; i_mem_rdata = 1'b0;
    i_op0 = 2'b10; i_op1 = 2'b10; i_op2 = 2'b10;
    i_addr0 = 6'd0; i_addr1 = 6'd0; i_addr2 = 6'd0;
    step(); step();
    chk("rst_grant", o_grant, 3'b000);
    chk("rst_op", o_mem_operation, 2'b10);
    chk("rst_busy", o_busy, 1'b0);

    // Single read from requester 0
    rst = 1'b0; i_req = 3'b001; i_op0 = 2'b00; i_addr0 = 6'd17; i_mem_rdata = 1'b1;
    step();
    chk("rd_grant", o_grant, 3'b001);
    chk("rd_op", o_mem_operation, 2'b00);
    chk("rd_addr", o_mem_address, 6'd17);
    i_req = 3'b000;
    step(); step(); step();
    chk("rd_hold_addr", o_mem_address, 6'd17);
    step();
    chk("rd_done", o_done, 3'b001);
    chk("rd_rdata", o_rdata, 1'b1);
    step();

    // Write from requester 1
    i_req = 3'b010; i_op1 = 2'b01; i_addr1 = 6'd63; i_wdata = 3'b010;
    step();
    chk("wr_wdata", o_mem_wdata, 1'b1);
    chk("wr_addr", o_mem_address, 6'd63);
    i_req = 3'b000;
    for (int n = 0; n < OPC; n++) step();
    chk("wr_done", o_done, 3'b010);
    step();

    // Fairness with all three requesting from a fresh reset
    rst = 1'b1; step(); rst = 1'b0;
    i_req = 3'b111; i_op0 = 2'b00; i_op1 = 2'b01; i_op2 = 2'b11;
    i_addr0 = 6'd1; i_addr1 = 6'd2; i_addr2 = 6'd3;
    for (int n = 0; n < 40 && dn_val.size() < 3; n++) begin
      step();
      if (o_done != 3'b000) begin
        dn_cyc.push_back(cyc);
        dn_val.push_back(o_done);
      end
    end
    i_req = 3'b000;
    chk("fair_count", dn_val.size(), 3);
    if (dn_val.size() == 3) begin
      chk("fair_0", dn_val[0], 3'b001);
      chk("fair_1", dn_val[1], 3'b010);
      chk("fair_2", dn_val[2], 3'b100);
      chk("fair_gap01", dn_cyc[1] - dn_cyc[0], 6);
      chk("fair_gap12", dn_cyc[2] - dn_cyc[1], 6);
    end
    step();

    // Inputs change mid-operation: latched values must hold
    i_req = 3'b001; i_op0 = 2'b00; i_addr0 = 6'd9; i_wdata = 3'b000;
    step();
    chk("mid_grant", o_grant, 3'b001);
    i_req = 3'b000; i_addr0 = 6'd40; i_op0 = 2'b01; i_wdata = 3'b111;
    for (int n = 0; n < OPC - 1; n++) begin
      step();
      chk("mid_addr", o_mem_address, 6'd9);
      chk("mid_op", o_mem_operation, 2'b00);
      chk("mid_wdata", o_mem_wdata, 1'b0);
    end
    step();
    chk("mid_done", o_done, 3'b001);
    step();

    // Reset abort in the second active cycle
    i_req = 3'b010; i_op1 = 2'b01; i_addr1 = 6'd33;
    step();
    chk("ab_grant", o_grant, 3'b010);
    step();
    rst = 1'b1; i_req = 3'b100;
    step();
    chk("ab_rst_grant", o_grant, 3'b000);
    chk("ab_rst_done", o_done, 3'b000);
    chk("ab_rst_busy", o_busy, 1'b0);
    chk("ab_rst_addr", o_mem_address, 6'd0);
    rst = 1'b0;
    step();
    chk("ab_req2_grant", o_grant, 3'b100);
    step();
    rst = 1'b1; i_req = 3'b101;
    step();
    rst = 1'b0;
    step();
    chk("ab_req0_grant", o_grant, 3'b001);
    i_req = 3'b000;
    for (int n = 0; n < OPC + 1; n++) step();

    // OP_CYCLES = 1 instance
    rst = 1'b1; step(); rst = 1'b0;
    i_req = 3'b001; i_op0 = 2'b00; i_addr0 = 6'd5; i_wdata = 3'b000; i_mem_rdata = 1'b1;
    step();
    chk("op1_grant", q_grant, 3'b001);
    chk("op1_op", q_mem_operation, 2'b00);
    chk("op1_addr", q_mem_address, 6'd5);
    chk("op1_wdata", q_mem_wdata, 1'b0);
    i_req = 3'b000;
    step();
    chk("op1_done", q_done, 3'b001);
    chk("op1_grant_clr", q_grant, 3'b000);
    chk("op1_rdata", q_rdata, 1'b1);
    step();
    chk("op1_done_clr", q_done, 3'b000);
    chk("op1_busy", q_busy, 1'b0);

    // Random traffic against the model
    for (int n = 0; n < 500; n++) begin
      rst         = ($urandom_range(0, 49) == 0);
      i_req       = ($urandom_range(0, 3) == 0) ? 3'b000 : 3'($urandom);
      i_op0       = 2'($urandom); i_op1 = 2'($urandom); i_op2 = 2'($urandom);
      i_addr0     = 6'($urandom); i_addr1 = 6'($urandom); i_addr2 = 6'($urandom);
      i_wdata     = 3'($urandom);
      i_mem_rdata = 1'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/memory_port_arbiter.md
MEMORY_PORT_ARBITER -- requirements
Module: memory_port_arbiter

Interface
REQ-001 Parameter OP_CYCLES, default 4: clock cycles each granted memory operation is held on the memory port; legal range 1-15.
REQ-002 Parameter ADDR_W, default 6: cell address width (64-cell board).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 i_req  input  3  request per requester; index 0 = cgol engine, 1 = output controller, 2 = seed loader.
REQ-006 i_op0, i_op1, i_op2  input  2 each  requested operation per requester: 00 READ, 01 WRITE, 10 IDLE, 11 CYCLE_REG.
REQ-007 i_addr0, i_addr1, i_addr2  input  ADDR_W each  requested cell address per requester.
REQ-008 i_wdata  input  3  write data bit per requester, same index order as i_req.
REQ-009 o_grant  output  3  one-hot grant, or all zero when the port is free.
REQ-010 o_done  output  3  one-cycle completion pulse to the granted requester.
REQ-011 o_rdata  output  1  read data, broadcast to all requesters, valid in the o_done cycle.
REQ-012 o_mem_operation  output  2  operation code driven to memory_controller.
REQ-013 o_mem_address  output  ADDR_W  address driven to memory_controller.
REQ-014 o_mem_wdata  output  1  write data driven to memory_controller.
REQ-015 i_mem_rdata  input  1  read data returned from memory_controller.
REQ-016 o_busy  output  1  high whenever the FSM is not in S_IDLE.

Function
REQ-017 FSM states: S_IDLE, S_ACTIVE, S_DONE; reset state is S_IDLE.
REQ-018 S_IDLE with i_req nonzero: select one requester, latch its op, addr and wdata, load the hold counter to 0, set the matching o_grant bit, and move to S_ACTIVE on the next edge.
REQ-019 Selection: round-robin starting at (last_granted+1) mod 3; last_granted resets to 2 so requester 0 wins first.
REQ-020 S_ACTIVE: drive the latched op, address and wdata on o_mem_*; increment the hold counter each cycle.
REQ-021 S_ACTIVE, counter = OP_CYCLES-1: capture i_mem_rdata into the o_rdata register and move to S_DONE.
REQ-022 S_DONE, one cycle only: pulse the granted o_done bit, hold o_rdata, clear o_grant, update last_granted, and return to S_IDLE.
REQ-023 o_mem_* are held stable for exactly OP_CYCLES consecutive cycles per grant.
REQ-024 Latency: request sampled at cycle T; grant and memory op from T+1 to T+OP_CYCLES; o_done at T+OP_CYCLES+1; the next grant is no earlier than T+OP_CYCLES+2.
REQ-025 Outside S_ACTIVE: o_mem_operation = 10 (IDLE), o_mem_address = 0, o_mem_wdata = 0.
REQ-026 i_req, i_op*, i_addr* and i_wdata are sampled only in S_IDLE; changes during S_ACTIVE or S_DONE are ignored.
REQ-027 A requester that drops i_req mid-operation still receives its o_done; the operation is not aborted.
REQ-028 An IDLE or CYCLE_REG op is granted and timed like any other; o_rdata then carries whatever i_mem_rdata was at capture.
REQ-029 A requester holding i_req high continuously is re-arbitrated each time; with all three requesting, the grant order is 0,1,2,0,...
REQ-030 o_grant and o_done are each at most one-hot; o_done is never asserted outside S_DONE.
REQ-031 The hold counter is $clog2(OP_CYCLES)+1 bits wide and does not wrap within a grant.

Reset
REQ-032 rst high at an edge forces S_IDLE, o_grant = 0, o_done = 0, o_rdata = 0, o_busy = 0, o_mem_operation = 10, o_mem_address = 0, o_mem_wdata = 0, hold counter = 0, last_granted = 2.
REQ-033 rst mid-operation abandons the grant without an o_done pulse; arbitration resumes on the first cycle after rst deasserts.

Verification
REQ-034 Single read: i_req=001, i_op0=00, i_addr0=6'd17, i_mem_rdata=1 -> o_grant=001 for 4 cycles, o_mem_operation=00, o_mem_address=17, then o_done=001 with o_rdata=1.
REQ-035 Write: i_req=010, i_op1=01, i_addr1=63, i_wdata=010 -> o_mem_wdata=1 and o_mem_address=63 for 4 cycles, then o_done=010.
REQ-036 Fairness: i_req=111 held for 3 grants -> grant order 001, 010, 100, with o_done pulses 6 cycles apart.
REQ-037 Mid-operation change: after grant 0, switch i_addr0 and i_op0 and drop i_req -> o_mem_* stay at the latched values and o_done=001 still fires.
REQ-038 Reset abort: assert rst in the 2nd S_ACTIVE cycle -> next cycle all outputs at their REQ-032 values and no o_done pulse; with i_req=100 after release, requester 0 wins if also requesting, otherwise requester 2 is granted.
REQ-039 OP_CYCLES=1: single read -> grant for 1 cycle and o_done on the following cycle.
